// File: rtl/mvb_fifo_pkg.sv
// Shared helpers for the MVB FIFO: pointer width, count type and flag thresholds.
package mvb_fifo_pkg;

    typedef logic [31:0] cnt_t;

    // One extra MSB lets equal low bits distinguish full from empty.
    function automatic int ptr_w(input int items);
        return $clog2(items) + 1;
    endfunction

    function automatic logic afull_chk(input cnt_t items, input cnt_t cnt, input cnt_t offset);
        return (items - cnt) <= offset;
    endfunction

    function automatic logic aempty_chk(input cnt_t cnt, input cnt_t offset);
        return cnt <= offset;
    endfunction

endpackage

// File: rtl/mvb_fifo_sync_if.sv
// MVB bus: REGIONS items per word with per-item valid and a src/dst ready handshake.
interface mvb_fifo_sync_if #(
    parameter int REGIONS    = 4,
    parameter int ITEM_WIDTH = 8
);
    logic [REGIONS*ITEM_WIDTH-1:0] data;
    logic [REGIONS-1:0]            vld;
    logic                          src_rdy;
    logic                          dst_rdy;

    modport master (output data, vld, src_rdy, input dst_rdy);
    modport slave  (input data, vld, src_rdy, output dst_rdy);
endinterface

// File: rtl/mvb_fifo_mem.sv
// Simple dual-port storage with a one-cycle registered read; read data holds when i_re is low.
module mvb_fifo_mem #(
    parameter int    WIDTH  = 36,
    parameter int    DEPTH  = 1024,
    parameter string DEVICE = "ULTRASCALE"
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // DEVICE only steers the inferred RAM flavour; behaviour is identical.
    if (DEVICE == "ULTRASCALE" || DEVICE == "7SERIES") begin : g_bram
        (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
        always_ff @(posedge i_clk) begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            if (i_re) o_rdata <= r_mem[i_raddr];
        end
    end else begin : g_dist
        (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];
        always_ff @(posedge i_clk) begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            if (i_re) o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/mvb_fifo_sync.sv
// Synchronous MVB FIFO, first-word-fall-through through a registered output stage.
// Define MVB_FIFO_STATUS_EN to drive o_status with the stored-word count (else constant 0).
module mvb_fifo_sync
    import mvb_fifo_pkg::*;
#(
    parameter int    REGIONS       = 4,
    parameter int    ITEM_WIDTH    = 8,
    parameter int    ITEMS         = 1024,
    parameter int    AFULL_OFFSET  = 4,
    parameter int    AEMPTY_OFFSET = 4,
    parameter string DEVICE        = "ULTRASCALE"
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mvb_fifo_sync_if.slave       i_rx,
    mvb_fifo_sync_if.master      o_tx,
    output logic                 o_afull,
    output logic                 o_aempty,
    output logic [$clog2(ITEMS):0] o_status
);

    localparam int PTR_W = ptr_w(ITEMS);
    localparam int AW    = PTR_W - 1;
    localparam int BW    = REGIONS * ITEM_WIDTH;
    localparam int DW    = REGIONS * (ITEM_WIDTH + 1);

    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, r_cnt, w_cnt_nxt;
    logic               r_mid_vld, r_out_vld, r_rx_rdy, r_afull, r_aempty;
    logic [BW-1:0]      r_out_data;
    logic [REGIONS-1:0] r_out_vldv;
    logic [DW-1:0]      w_rd_word, w_wr_word;
    logic               w_rx_fire, w_wr, w_tx_fire, w_out_free, w_mem_empty;
    logic               w_mid_mv, w_bypass, w_mem_we, w_mem_re;

    assign w_rx_fire   = i_rx.src_rdy && r_rx_rdy;
    assign w_wr        = w_rx_fire && (|i_rx.vld);
    assign w_tx_fire   = r_out_vld && o_tx.dst_rdy;
    assign w_out_free  = !r_out_vld || w_tx_fire;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_word   = {i_rx.vld, i_rx.data};

    // Pipeline: memory -> mid (RAM read register) -> output stage.
    // A write into a completely empty path skips straight to the output stage.
    assign w_mid_mv = r_mid_vld && w_out_free;
    assign w_bypass = w_wr && w_mem_empty && !r_mid_vld && w_out_free;
    assign w_mem_we = w_wr && !w_bypass;
    assign w_mem_re = !w_mem_empty && (!r_mid_vld || w_out_free);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr && !w_tx_fire)
            w_cnt_nxt = r_cnt + PTR_W'(1);
        else if (!w_wr && w_tx_fire)
            w_cnt_nxt = r_cnt - PTR_W'(1);
    end

    mvb_fifo_mem #(
        .WIDTH  (DW),
        .DEPTH  (ITEMS),
        .DEVICE (DEVICE)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wr_word),
        .i_re    (w_mem_re),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_mid_vld  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_vldv <= '0;
            r_rx_rdy   <= 1'b0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            if (w_mem_we) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_mem_re) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            if (w_mem_re)      r_mid_vld <= 1'b1;
            else if (w_mid_mv) r_mid_vld <= 1'b0;

            if (w_mid_mv) begin
                r_out_data <= w_rd_word[BW-1:0];
                r_out_vldv <= w_rd_word[DW-1:BW];
                r_out_vld  <= 1'b1;
            end else if (w_bypass) begin
                r_out_data <= i_rx.data;
                r_out_vldv <= i_rx.vld;
                r_out_vld  <= 1'b1;
            end else if (w_tx_fire) begin
                r_out_vld  <= 1'b0;
            end

            // Ready derives from the next count, so a full FIFO stays closed in the cycle a read frees a slot.
            r_cnt    <= w_cnt_nxt;
            r_rx_rdy <= (w_cnt_nxt != PTR_W'(ITEMS));
            r_afull  <= afull_chk(cnt_t'(ITEMS), cnt_t'(w_cnt_nxt), cnt_t'(AFULL_OFFSET));
            r_aempty <= aempty_chk(cnt_t'(w_cnt_nxt), cnt_t'(AEMPTY_OFFSET));
        end
    end

    assign i_rx.dst_rdy = r_rx_rdy;
    assign o_tx.src_rdy = r_out_vld;
    assign o_tx.data    = r_out_data;
    assign o_tx.vld     = r_out_vld ? r_out_vldv : '0;
    assign o_afull      = r_afull;
    assign o_aempty     = r_aempty;

`ifdef MVB_FIFO_STATUS_EN
    assign o_status = r_cnt;
`else
    assign o_status = '0;
`endif

endmodule

// File: tb/tb_mvb_fifo_sync.sv
// Directed bench for mvb_fifo_sync (ITEMS=16): reset, latency, drop, fill/full-read, reset mid-run, random wrap.
module tb_mvb_fifo_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       afull, aempty;
    logic [4:0] status;
    int         checks = 0;
    int         errors = 0;
    logic [35:0] sb[$];

    mvb_fifo_sync_if #(.REGIONS(4), .ITEM_WIDTH(8)) rx_if ();
    mvb_fifo_sync_if #(.REGIONS(4), .ITEM_WIDTH(8)) tx_if ();

    mvb_fifo_sync #(
        .REGIONS(4), .ITEM_WIDTH(8), .ITEMS(16),
        .AFULL_OFFSET(4), .AEMPTY_OFFSET(4), .DEVICE("ULTRASCALE")
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_rx     (rx_if),
        .o_tx     (tx_if),
        .o_afull  (afull),
        .o_aempty (aempty),
        .o_status (status)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_st(input int n);
`ifdef MVB_FIFO_STATUS_EN
        return 5'(n);
`else
        return (n >= 0) ? 5'd0 : 5'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rx_if.src_rdy = 1'b0; rx_if.vld = '0; rx_if.data = '0; tx_if.dst_rdy = 1'b0;
        #2 rst_n = 1'b0;
        step(); step();
        checks++; if (rx_if.dst_rdy !== 1'b0) begin errors++; $display("FAIL rst_rx_rdy got %b exp 0", rx_if.dst_rdy); end
        checks++; if (tx_if.src_rdy !== 1'b0) begin errors++; $display("FAIL rst_tx_src got %b exp 0", tx_if.src_rdy); end
        checks++; if (tx_if.vld !== 4'h0) begin errors++; $display("FAIL rst_tx_vld got %h exp 0", tx_if.vld); end
        checks++; if (afull !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL rst_flags got af=%b ae=%b exp af=0 ae=1", afull, aempty); end
        checks++; if (status !== 5'd0) begin errors++; $display("FAIL rst_status got %0d exp 0", status); end
        rst_n = 1'b1;
        #1;
        checks++; if (rx_if.dst_rdy !== 1'b0) begin errors++; $display("FAIL rel_rx_rdy_early got %b exp 0", rx_if.dst_rdy); end
        step();
        checks++; if (rx_if.dst_rdy !== 1'b1) begin errors++; $display("FAIL rel_rx_rdy got %b exp 1", rx_if.dst_rdy); end
    endtask

    task automatic test_latency();
        rx_if.data = 32'hA1B2C3D4; rx_if.vld = 4'hF; rx_if.src_rdy = 1'b1;
        step();
        rx_if.src_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b1) begin errors++; $display("FAIL lat_src got %b exp 1", tx_if.src_rdy); end
        checks++; if ({tx_if.vld, tx_if.data} !== 36'hF_A1B2C3D4) begin errors++; $display("FAIL lat_data got %h exp FA1B2C3D4", {tx_if.vld, tx_if.data}); end
        checks++; if (status !== exp_st(1) || aempty !== 1'b1) begin errors++; $display("FAIL lat_status got st=%0d ae=%b exp st=%0d ae=1", status, aempty, exp_st(1)); end
        step();
        checks++; if (tx_if.src_rdy !== 1'b1 || tx_if.data !== 32'hA1B2C3D4) begin errors++; $display("FAIL hold_data got %b/%h exp 1/A1B2C3D4", tx_if.src_rdy, tx_if.data); end
        tx_if.dst_rdy = 1'b1;
        step();
        tx_if.dst_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b0 || status !== exp_st(0)) begin errors++; $display("FAIL lat_drain got src=%b st=%0d exp src=0 st=0", tx_if.src_rdy, status); end
    endtask

    task automatic test_drop();
        rx_if.data = 32'h12345678; rx_if.vld = 4'h0; rx_if.src_rdy = 1'b1;
        step();
        rx_if.src_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b0 || status !== exp_st(0)) begin errors++; $display("FAIL drop_now got src=%b st=%0d exp src=0 st=0", tx_if.src_rdy, status); end
        step(); step();
        checks++; if (tx_if.src_rdy !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL drop_late got src=%b ae=%b exp src=0 ae=1", tx_if.src_rdy, aempty); end
    endtask

    task automatic test_fill_full_read();
        logic [35:0] exp;
        tx_if.dst_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx_if.data = 32'hC0DE0000 + 32'(i); rx_if.vld = 4'((i % 15) + 1); rx_if.src_rdy = 1'b1;
            step();
            if (i + 1 == 5) begin
                checks++; if (aempty !== 1'b0) begin errors++; $display("FAIL aempty_at5 got %b exp 0", aempty); end
            end
            if (i + 1 == 11) begin
                checks++; if (afull !== 1'b0) begin errors++; $display("FAIL afull_at11 got %b exp 0", afull); end
            end
            if (i + 1 == 12) begin
                checks++; if (afull !== 1'b1) begin errors++; $display("FAIL afull_at12 got %b exp 1", afull); end
            end
            if (i + 1 == 15) begin
                checks++; if (rx_if.dst_rdy !== 1'b1) begin errors++; $display("FAIL rdy_at15 got %b exp 1", rx_if.dst_rdy); end
            end
        end
        checks++; if (rx_if.dst_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", rx_if.dst_rdy); end
        checks++; if (status !== exp_st(16) || afull !== 1'b1) begin errors++; $display("FAIL full_status got st=%0d af=%b exp st=%0d af=1", status, afull, exp_st(16)); end
        // Offer another word while reading once: only the read may happen.
        rx_if.data = 32'hDEADBEEF; rx_if.vld = 4'hF; rx_if.src_rdy = 1'b1; tx_if.dst_rdy = 1'b1;
        step();
        rx_if.src_rdy = 1'b0; tx_if.dst_rdy = 1'b0;
        checks++; if (status !== exp_st(15) || rx_if.dst_rdy !== 1'b1) begin errors++; $display("FAIL fullrd got st=%0d rdy=%b exp st=%0d rdy=1", status, rx_if.dst_rdy, exp_st(15)); end
        tx_if.dst_rdy = 1'b1;
        for (int i = 1; i < 16; i++) begin
            exp = {4'((i % 15) + 1), 32'hC0DE0000 + 32'(i)};
            checks++;
            if (tx_if.src_rdy !== 1'b1 || {tx_if.vld, tx_if.data} !== exp) begin
                errors++; $display("FAIL drain_%0d got src=%b %h exp src=1 %h", i, tx_if.src_rdy, {tx_if.vld, tx_if.data}, exp);
            end
            step();
        end
        tx_if.dst_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b0 || aempty !== 1'b1 || afull !== 1'b0) begin errors++; $display("FAIL drained got src=%b ae=%b af=%b exp 0/1/0", tx_if.src_rdy, aempty, afull); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            rx_if.data = 32'hBEEF0000 + 32'(i); rx_if.vld = 4'hF; rx_if.src_rdy = 1'b1;
            step();
        end
        rx_if.src_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_if.src_rdy !== 1'b0 || tx_if.vld !== 4'h0) begin errors++; $display("FAIL midrst_tx got src=%b vld=%h exp 0/0", tx_if.src_rdy, tx_if.vld); end
        checks++; if (aempty !== 1'b1 || status !== 5'd0 || rx_if.dst_rdy !== 1'b0) begin errors++; $display("FAIL midrst_flags got ae=%b st=%0d rdy=%b exp 1/0/0", aempty, status, rx_if.dst_rdy); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (tx_if.src_rdy !== 1'b0 || rx_if.dst_rdy !== 1'b1) begin errors++; $display("FAIL postrst got src=%b rdy=%b exp 0/1", tx_if.src_rdy, rx_if.dst_rdy); end
        rx_if.data = 32'h55AA55AA; rx_if.vld = 4'h3; rx_if.src_rdy = 1'b1;
        step();
        rx_if.src_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b1 || {tx_if.vld, tx_if.data} !== 36'h3_55AA55AA) begin errors++; $display("FAIL postrst_first got src=%b %h exp 1 355AA55AA", tx_if.src_rdy, {tx_if.vld, tx_if.data}); end
        tx_if.dst_rdy = 1'b1;
        step();
        tx_if.dst_rdy = 1'b0;
        checks++; if (tx_if.src_rdy !== 1'b0) begin errors++; $display("FAIL postrst_empty got %b exp 0", tx_if.src_rdy); end
    endtask

    task automatic test_wrap_random();
        int pushed = 0;
        int cyc = 0;
        logic [35:0] exp;
        sb.delete();
        while (pushed < 10000 && cyc < 60000) begin
            checks++;
            if (aempty !== (sb.size() <= 4) || afull !== ((16 - sb.size()) <= 4) || status !== exp_st(sb.size())) begin
                errors++; $display("FAIL rnd_flags cyc %0d got ae=%b af=%b st=%0d exp cnt=%0d", cyc, aempty, afull, status, sb.size());
            end
            rx_if.src_rdy = 1'($urandom_range(0, 1));
            rx_if.vld     = 4'($urandom_range(0, 15));
            rx_if.data    = $urandom();
            tx_if.dst_rdy = 1'($urandom_range(0, 1));
            if (tx_if.src_rdy === 1'b1 && tx_if.dst_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rnd_phantom cyc %0d got %h exp none", cyc, {tx_if.vld, tx_if.data});
                end else begin
                    exp = sb.pop_front();
                    if ({tx_if.vld, tx_if.data} !== exp) begin
                        errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, {tx_if.vld, tx_if.data}, exp);
                    end
                end
            end
            if (rx_if.src_rdy && rx_if.dst_rdy === 1'b1 && (|rx_if.vld)) begin
                sb.push_back({rx_if.vld, rx_if.data});
                pushed++;
            end
            step();
            cyc++;
        end
        checks++; if (pushed < 10000) begin errors++; $display("FAIL rnd_budget got %0d exp 10000 words", pushed); end
        rx_if.src_rdy = 1'b0; tx_if.dst_rdy = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            if (tx_if.src_rdy === 1'b1) begin
                exp = sb.pop_front();
                checks++;
                if ({tx_if.vld, tx_if.data} !== exp) begin errors++; $display("FAIL rnd_drain got %h exp %h", {tx_if.vld, tx_if.data}, exp); end
            end
            step();
            cyc++;
        end
        tx_if.dst_rdy = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout got %0d left exp 0", sb.size()); end
        checks++; if (tx_if.src_rdy !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL rnd_end got src=%b ae=%b exp 0/1", tx_if.src_rdy, aempty); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drop();
        test_fill_full_read();
        test_reset_mid();
        test_wrap_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
